// File: rtl/axi4_lite_native_bridge.sv
// AXI4-lite slave that replays each read or write as one single-beat request on a
// native valid/ready memory bus, with fair read/write arbitration and optional stall timeout.
module axi4_lite_native_bridge #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, READ, WRITE, RRESP, BRESP} state_t;
  state_t state_reg, state_next;

  logic          ar_full_reg, aw_full_reg, w_full_reg;
  logic [31:0]   ar_addr_reg, aw_addr_reg, w_data_reg;
  logic          ar_instr_reg;
  logic [3:0]    w_strb_reg;
  logic          last_was_write_reg;
  logic [CW-1:0] to_cnt_reg;

  logic read_pend, write_pend, grant_read, grant_write;
  logic native_done, timed_out, timeout_hit;
  logic unused_bits;

  assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot[1:0]};

  // Readys follow only the latch state; resetn gates them so they drop the instant reset asserts.
  assign mem_axi_arready = resetn && !ar_full_reg;
  assign mem_axi_awready = resetn && !aw_full_reg;
  assign mem_axi_wready  = resetn && !w_full_reg;

  assign read_pend   = ar_full_reg;
  assign write_pend  = aw_full_reg && w_full_reg;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    grant_read  = 1'b0;
    grant_write = 1'b0;
    native_done = 1'b0;
    timed_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (write_pend && (!read_pend || !last_was_write_reg)) begin
          grant_write = 1'b1;
          state_next  = WRITE;
        end else if (read_pend) begin
          grant_read = 1'b1;
          state_next = READ;
        end
      end
      READ, WRITE: begin
        // mem_ready wins over a timeout landing on the same edge.
        if (mem_ready) begin
          native_done = 1'b1;
        end else if (timeout_hit) begin
          native_done = 1'b1;
          timed_out   = 1'b1;
        end
        if (native_done) state_next = (state_reg == READ) ? RRESP : BRESP;
      end
      RRESP:   if (mem_axi_rready) state_next = IDLE;
      BRESP:   if (mem_axi_bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_full_reg        <= 1'b0;
      aw_full_reg        <= 1'b0;
      w_full_reg         <= 1'b0;
      ar_addr_reg        <= '0;
      aw_addr_reg        <= '0;
      w_data_reg         <= '0;
      ar_instr_reg       <= 1'b0;
      w_strb_reg         <= '0;
      last_was_write_reg <= 1'b0;
      to_cnt_reg         <= '0;
      mem_valid          <= 1'b0;
      mem_instr          <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      mem_wstrb          <= '0;
      mem_axi_rvalid     <= 1'b0;
      mem_axi_rdata      <= '0;
      mem_axi_bvalid     <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      if (mem_axi_arvalid && mem_axi_arready) begin
        ar_full_reg  <= 1'b1;
        ar_addr_reg  <= mem_axi_araddr;
        ar_instr_reg <= mem_axi_arprot[2];
      end else if (native_done && state_reg == READ) begin
        ar_full_reg <= 1'b0;
      end

      if (mem_axi_awvalid && mem_axi_awready) begin
        aw_full_reg <= 1'b1;
        aw_addr_reg <= mem_axi_awaddr;
      end else if (native_done && state_reg == WRITE) begin
        aw_full_reg <= 1'b0;
      end

      if (mem_axi_wvalid && mem_axi_wready) begin
        w_full_reg <= 1'b1;
        w_data_reg <= mem_axi_wdata;
        w_strb_reg <= mem_axi_wstrb;
      end else if (native_done && state_reg == WRITE) begin
        w_full_reg <= 1'b0;
      end

      if (grant_read || grant_write) begin
        mem_valid          <= 1'b1;
        mem_addr           <= grant_write ? aw_addr_reg : ar_addr_reg;
        mem_wdata          <= grant_write ? w_data_reg : 32'd0;
        mem_wstrb          <= grant_write ? w_strb_reg : 4'd0;
        mem_instr          <= grant_write ? 1'b0 : ar_instr_reg;
        last_was_write_reg <= grant_write;
        to_cnt_reg         <= '0;
      end else if (mem_valid && !mem_ready) begin
        to_cnt_reg <= to_cnt_reg + CW'(1);
      end

      if (native_done) begin
        mem_valid <= 1'b0;
        if (state_reg == READ) begin
          mem_axi_rdata  <= timed_out ? 32'd0 : mem_rdata;
          mem_axi_rvalid <= 1'b1;
        end else begin
          mem_axi_bvalid <= 1'b1;
        end
        if (timed_out) timeout_err <= 1'b1;
      end

      if (state_reg == RRESP && mem_axi_rready) mem_axi_rvalid <= 1'b0;
      if (state_reg == BRESP && mem_axi_bready) mem_axi_bvalid <= 1'b0;
    end
  end

endmodule
